// File: rtl/century_clock_pkg.sv
// Shared types and helpers for the century clock BCD counter stages.
package century_clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ZERO = 4'h0;
  localparam bcd_digit_t BCD_NINE = 4'h9;

  // Decimal to packed BCD, up to eight digits; higher digits are dropped.
  function automatic logic [31:0] to_bcd(input int unsigned val);
    logic [31:0] res;
    int unsigned rem;
    res = '0;
    rem = val;
    for (int i = 0; i < 8; i++) begin
      res[4*i +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Single BCD digit increment or decrement with ripple carry/borrow in and out.
module bcd_digit_step
  import century_clock_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dec,
  input  logic       cin,
  output logic [3:0] result,
  output logic       cout
);

  always_comb begin
    result = digit;
    cout   = 1'b0;
    if (cin) begin
      if (!dec) begin
        if (digit >= BCD_NINE) begin
          result = BCD_ZERO;
          cout   = 1'b1;
        end else begin
          result = digit + 4'd1;
        end
      end else begin
        if (digit == BCD_ZERO) begin
          result = BCD_NINE;
          cout   = 1'b1;
        end else begin
          result = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_range_counter.sv
// Packed-BCD counter with programmable upper bound, parallel load and manual adjust.
// Optional out-of-range clamp on idle cycles: BCD_RANGE_COUNTER_CLAMP_EN.
module bcd_range_counter
  import century_clock_pkg::*;
#(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MIN_VAL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  tick,
  input  logic                  up,
  input  logic                  down,
  input  logic [4*DIGITS-1:0]   max_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic                  at_max,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [31:0]  MIN_FULL = to_bcd(MIN_VAL);
  localparam logic [W-1:0] MIN_BCD  = MIN_FULL[W-1:0];

  logic [DIGITS:0] inc_c;
  logic [DIGITS:0] dec_c;
  logic [W-1:0]    inc_val;
  logic [W-1:0]    dec_val;
  logic [W-1:0]    inc_next;
  logic [W-1:0]    dec_next;
  logic [W-1:0]    tick_next;
  logic [W-1:0]    manual_next;
  logic            load_ok;

  assign inc_c[0] = 1'b1;
  assign dec_c[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_step u_inc (
      .digit  (count[4*i +: 4]),
      .dec    (1'b0),
      .cin    (inc_c[i]),
      .result (inc_val[4*i +: 4]),
      .cout   (inc_c[i+1])
    );
    bcd_digit_step u_dec (
      .digit  (count[4*i +: 4]),
      .dec    (1'b1),
      .cin    (dec_c[i]),
      .result (dec_val[4*i +: 4]),
      .cout   (dec_c[i+1])
    );
  end

  // Full-scale overflow/underflow falls back into the legal range.
  assign inc_next = inc_c[DIGITS] ? MIN_BCD : inc_val;
  assign dec_next = dec_c[DIGITS] ? max_val : dec_val;

  assign at_max    = (count >= max_val);
  assign tick_next = at_max ? MIN_BCD : inc_next;

  always_comb begin
    load_ok = (load_val >= MIN_BCD) && (load_val <= max_val);
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > BCD_NINE) load_ok = 1'b0;
    end
  end

  always_comb begin
    manual_next = count;
    if (up && !down) begin
      manual_next = tick_next;
    end else if (down && !up) begin
      if ((count == MIN_BCD) || (count > max_val)) manual_next = max_val;
      else                                          manual_next = dec_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= MIN_BCD;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        count <= MIN_BCD;
      end else if (load) begin
        if (load_ok) count    <= load_val;
        else         load_err <= 1'b1;
      end else if (tick) begin
        count <= tick_next;
        carry <= at_max;
      end else begin
`ifdef BCD_RANGE_COUNTER_CLAMP_EN
        if (count > max_val) count <= max_val;
        else                 count <= manual_next;
`else
        count <= manual_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bcd_range_counter.sv
// Directed self-checking bench: seconds (2 digits, min 0), day/month (2 digits, min 1), 4-digit year.
module tb_bcd_range_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // a: DIGITS=2, MIN_VAL=0
  logic       a_clr = 0, a_load = 0, a_tick = 0, a_up = 0, a_down = 0;
  logic [7:0] a_load_val = 0, a_max = 8'h59, a_count;
  logic       a_carry, a_at_max, a_load_err;
  // b: DIGITS=2, MIN_VAL=1
  logic       b_clr = 0, b_load = 0, b_tick = 0, b_up = 0, b_down = 0;
  logic [7:0] b_load_val = 0, b_max = 8'h31, b_count;
  logic       b_carry, b_at_max, b_load_err;
  // c: DIGITS=4, MIN_VAL=0
  logic        c_clr = 0, c_load = 0, c_tick = 0, c_up = 0, c_down = 0;
  logic [15:0] c_load_val = 0, c_max = 16'h9999, c_count;
  logic        c_carry, c_at_max, c_load_err;

  bcd_range_counter #(.DIGITS(2), .MIN_VAL(0)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load), .load_val(a_load_val),
    .tick(a_tick), .up(a_up), .down(a_down), .max_val(a_max), .count(a_count),
    .carry(a_carry), .at_max(a_at_max), .load_err(a_load_err));

  bcd_range_counter #(.DIGITS(2), .MIN_VAL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .load(b_load), .load_val(b_load_val),
    .tick(b_tick), .up(b_up), .down(b_down), .max_val(b_max), .count(b_count),
    .carry(b_carry), .at_max(b_at_max), .load_err(b_load_err));

  bcd_range_counter #(.DIGITS(4), .MIN_VAL(0)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .load(c_load), .load_val(c_load_val),
    .tick(c_tick), .up(c_up), .down(c_down), .max_val(c_max), .count(c_count),
    .carry(c_carry), .at_max(c_at_max), .load_err(c_load_err));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++; if (a_count !== 8'h00) begin errors++; $display("FAIL reset_a_count got %h want 00", a_count); end
    checks++; if (b_count !== 8'h01) begin errors++; $display("FAIL reset_b_count got %h want 01", b_count); end
    checks++; if (c_count !== 16'h0000) begin errors++; $display("FAIL reset_c_count got %h want 0000", c_count); end
    checks++; if (a_carry !== 1'b0 || a_load_err !== 1'b0) begin errors++; $display("FAIL reset_flags got carry=%b err=%b want 0 0", a_carry, a_load_err); end
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++; if (a_count !== 8'h00) begin errors++; $display("FAIL post_reset_hold got %h want 00", a_count); end
  endtask

  task automatic test_seconds();
    logic [7:0] exp;
    a_max = 8'h59;
    a_tick = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 60) begin
        checks++; if (a_at_max !== 1'b1) begin errors++; $display("FAIL sec_at_max_59 got %b want 1", a_at_max); end
      end
      cyc();
      exp = {4'((k % 60) / 10), 4'(k % 10)};
      checks++; if (a_count !== exp) begin errors++; $display("FAIL sec_count tick=%0d got %h want %h", k, a_count, exp); end
      checks++; if (a_carry !== (k == 60)) begin errors++; $display("FAIL sec_carry tick=%0d got %b want %b", k, a_carry, (k == 60)); end
    end
    a_tick = 1'b0;
    cyc();
    checks++; if (a_carry !== 1'b0 || a_count !== 8'h00) begin errors++; $display("FAIL sec_carry_single got carry=%b count=%h want 0 00", a_carry, a_count); end
  endtask

  task automatic test_month_change();
    b_max = 8'h31; b_load_val = 8'h31; b_load = 1'b1;
    cyc();
    b_load = 1'b0;
    checks++; if (b_count !== 8'h31) begin errors++; $display("FAIL day_load31 got %h want 31", b_count); end
    b_max = 8'h28;
    #1;
    checks++; if (b_at_max !== 1'b1) begin errors++; $display("FAIL day_at_max_comb got %b want 1", b_at_max); end
    cyc();
`ifdef BCD_RANGE_COUNTER_CLAMP_EN
    checks++; if (b_count !== 8'h28) begin errors++; $display("FAIL day_clamp got %h want 28", b_count); end
`else
    checks++; if (b_count !== 8'h31) begin errors++; $display("FAIL day_hold_oor got %h want 31", b_count); end
`endif
    b_tick = 1'b1;
    cyc();
    b_tick = 1'b0;
    checks++; if (b_count !== 8'h01 || b_carry !== 1'b1) begin errors++; $display("FAIL day_wrap got count=%h carry=%b want 01 1", b_count, b_carry); end
  endtask

  task automatic test_manual();
    b_max = 8'h12;
    b_clr = 1'b1; cyc(); b_clr = 1'b0;
    b_down = 1'b1; cyc(); b_down = 1'b0;
    checks++; if (b_count !== 8'h12 || b_carry !== 1'b0) begin errors++; $display("FAIL man_down_min got count=%h carry=%b want 12 0", b_count, b_carry); end
    b_up = 1'b1; cyc(); b_up = 1'b0;
    checks++; if (b_count !== 8'h01 || b_carry !== 1'b0) begin errors++; $display("FAIL man_up_max got count=%h carry=%b want 01 0", b_count, b_carry); end
    b_up = 1'b1; b_down = 1'b1; cyc(); b_up = 1'b0; b_down = 1'b0;
    checks++; if (b_count !== 8'h01) begin errors++; $display("FAIL man_both_hold got %h want 01", b_count); end
    b_load_val = 8'h10; b_load = 1'b1; cyc(); b_load = 1'b0;
    b_down = 1'b1; cyc(); b_down = 1'b0;
    checks++; if (b_count !== 8'h09) begin errors++; $display("FAIL man_down_borrow got %h want 09", b_count); end
    b_up = 1'b1; cyc(); b_up = 1'b0;
    checks++; if (b_count !== 8'h10) begin errors++; $display("FAIL man_up_carry got %h want 10", b_count); end
  endtask

  task automatic test_load();
    logic [7:0] bad [3];
    bad[0] = 8'h1A; bad[1] = 8'h45; bad[2] = 8'h00;
    b_max = 8'h31;
    b_clr = 1'b1; cyc(); b_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_load_val = bad[i]; b_load = 1'b1;
      cyc();
      b_load = 1'b0;
      checks++; if (b_load_err !== 1'b1 || b_count !== 8'h01) begin errors++; $display("FAIL load_reject val=%h got err=%b count=%h want 1 01", bad[i], b_load_err, b_count); end
      cyc();
      checks++; if (b_load_err !== 1'b0) begin errors++; $display("FAIL load_err_pulse val=%h got %b want 0", bad[i], b_load_err); end
    end
    b_load_val = 8'h17; b_load = 1'b1;
    cyc();
    b_load = 1'b0;
    checks++; if (b_count !== 8'h17 || b_load_err !== 1'b0) begin errors++; $display("FAIL load_accept got count=%h err=%b want 17 0", b_count, b_load_err); end
  endtask

  task automatic test_priority();
    a_max = 8'h59;
    a_load_val = 8'h59; a_load = 1'b1; cyc();
    a_clr = 1'b1; a_load_val = 8'h30; a_tick = 1'b1;
    cyc();
    a_clr = 1'b0;
    checks++; if (a_count !== 8'h00 || a_carry !== 1'b0) begin errors++; $display("FAIL prio_clr got count=%h carry=%b want 00 0", a_count, a_carry); end
    a_load_val = 8'h59; cyc();
    a_load_val = 8'h20;
    cyc();
    a_load = 1'b0; a_tick = 1'b0;
    checks++; if (a_count !== 8'h20 || a_carry !== 1'b0) begin errors++; $display("FAIL prio_load_tick got count=%h carry=%b want 20 0", a_count, a_carry); end
  endtask

  task automatic test_back_to_back();
    a_max = 8'h00;
    a_clr = 1'b1; cyc(); a_clr = 1'b0;
    a_tick = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (a_count !== 8'h00 || a_carry !== 1'b1) begin errors++; $display("FAIL b2b_wrap n=%0d got count=%h carry=%b want 00 1", k, a_count, a_carry); end
    end
    a_tick = 1'b0;
    a_max = 8'h59;
  endtask

  task automatic test_four_digit();
    c_max = 16'h9999;
    c_load_val = 16'h0999; c_load = 1'b1; cyc(); c_load = 1'b0;
    c_tick = 1'b1; cyc(); c_tick = 1'b0;
    checks++; if (c_count !== 16'h1000 || c_carry !== 1'b0) begin errors++; $display("FAIL year_ripple got count=%h carry=%b want 1000 0", c_count, c_carry); end
    c_load_val = 16'h9999; c_load = 1'b1; cyc(); c_load = 1'b0;
    c_tick = 1'b1; cyc(); c_tick = 1'b0;
    checks++; if (c_count !== 16'h0000 || c_carry !== 1'b1) begin errors++; $display("FAIL year_wrap got count=%h carry=%b want 0000 1", c_count, c_carry); end
  endtask

  task automatic test_async_reset();
    a_load_val = 8'h45; a_load = 1'b1; cyc(); a_load = 1'b0;
    checks++; if (a_count !== 8'h45) begin errors++; $display("FAIL areset_setup got %h want 45", a_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_count !== 8'h00) begin errors++; $display("FAIL areset_immediate got %h want 00", a_count); end
    checks++; if (b_count !== 8'h01) begin errors++; $display("FAIL areset_min1 got %h want 01", b_count); end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_seconds();
    test_month_change();
    test_manual();
    test_load();
    test_priority();
    test_back_to_back();
    test_four_digit();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
